// File: rtl/div_unit_e.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit for the EX stage.
// Radix-2 restoring division, one quotient bit per cycle, with stall and flush handshake.
module div_unit_e #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StartE,
    input  logic [1:0]      DivOpE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            BusyE,
    output logic            DoneE,
    output logic [XLEN-1:0] ResultE
);

    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          r_state;
    logic [CntW-1:0] r_cnt;
    logic            r_sel_rem;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_quo;
    logic [XLEN-1:0] r_dvsr;
    logic [XLEN-1:0] r_result;

    logic            w_signed;
    logic            w_sign_a;
    logic            w_sign_b;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic [XLEN-1:0] w_min;
    logic            w_div_zero;
    logic            w_ovf;
    logic [XLEN:0]   w_rem_sh;
    logic            w_ge;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_rem_nx;
    logic [XLEN-1:0] w_quo_nx;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_quo_fix;
    logic            w_last;

    always_comb begin
        w_signed   = ~DivOpE[0];
        w_sign_a   = w_signed & SrcAE[XLEN-1];
        w_sign_b   = w_signed & SrcBE[XLEN-1];
        w_abs_a    = w_sign_a ? -SrcAE : SrcAE;
        w_abs_b    = w_sign_b ? -SrcBE : SrcBE;
        w_min      = {1'b1, {(XLEN-1){1'b0}}};
        w_div_zero = (SrcBE == '0);
        w_ovf      = w_signed & (SrcAE == w_min) & (SrcBE == '1);
    end

    // The shifted partial remainder is below 2*divisor, so the difference fits in XLEN bits
    // whenever the trial subtraction succeeds.
    always_comb begin
        w_rem_sh  = {r_rem, r_quo[XLEN-1]};
        w_ge      = (w_rem_sh >= {1'b0, r_dvsr});
        w_diff    = w_rem_sh[XLEN-1:0] - r_dvsr;
        w_rem_nx  = w_ge ? w_diff : w_rem_sh[XLEN-1:0];
        w_quo_nx  = {r_quo[XLEN-2:0], w_ge};
        w_rem_fix = r_neg_r ? -w_rem_nx : w_rem_nx;
        w_quo_fix = r_neg_q ? -w_quo_nx : w_quo_nx;
        w_last    = (r_cnt == CntW'(XLEN-1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_sel_rem <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvsr    <= '0;
            r_result  <= '0;
        end else if (FlushE) begin
            r_state <= StIdle;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (StartE) begin
                        r_sel_rem <= DivOpE[1];
                        r_neg_q   <= w_sign_a ^ w_sign_b;
                        r_neg_r   <= w_sign_a;
                        r_dvsr    <= w_abs_b;
                        r_cnt     <= '0;
                        if (w_div_zero) begin
                            r_result <= DivOpE[1] ? SrcAE : '1;
                            r_state  <= StDone;
                        end else if (w_ovf) begin
                            r_result <= DivOpE[1] ? '0 : w_min;
                            r_state  <= StDone;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_abs_a;
                            r_state <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_result <= r_sel_rem ? w_rem_fix : w_quo_fix;
                        r_state  <= StDone;
                    end
                end
                // StartE may still be high here: it is the finished instruction leaving E.
                StDone:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign BusyE   = ((r_state == StIdle) & StartE) | (r_state == StCalc);
    assign DoneE   = (r_state == StDone);
    assign ResultE = r_result;

endmodule

// File: tb/tb_div_unit_e.sv
// Self-checking bench for div_unit_e: arithmetic reference model plus directed vectors.
module tb_div_unit_e;

    logic        clk;
    logic        rst_n;
    logic        StartE;
    logic [1:0]  DivOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        FlushE;
    logic        BusyE;
    logic        DoneE;
    logic [31:0] ResultE;

    int tests;
    int fails;

    div_unit_e #(.XLEN(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .StartE  (StartE),
        .DivOpE  (DivOpE),
        .SrcAE   (SrcAE),
        .SrcBE   (SrcBE),
        .FlushE  (FlushE),
        .BusyE   (BusyE),
        .DoneE   (DoneE),
        .ResultE (ResultE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from plain 64-bit arithmetic (truncating division).
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return op[1] ? r[31:0] : q[31:0];
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Timing model: a normal op spends 32 cycles computing, special cases finish at once.
    int          m_left;
    bit          m_done;
    logic [31:0] m_res;
    logic [31:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = 32'd0;
            m_pend = 32'd0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            if (FlushE) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_res  = m_pend;
                end
            end
        end else if (StartE && !FlushE) begin
            m_pend = ref_div(DivOpE, SrcAE, SrcBE);
            if (is_special(DivOpE, SrcAE, SrcBE)) begin
                m_done = 1'b1;
                m_res  = m_pend;
            end else begin
                m_left = 32;
            end
        end
    end

    always @(negedge clk) begin
        logic exp_busy;
        exp_busy = (m_left > 0) || (!m_done && StartE);
        chk("busy", {31'd0, BusyE}, {31'd0, exp_busy});
        chk("done", {31'd0, DoneE}, {31'd0, m_done});
        chk("result", ResultE, m_res);
    end

    // Issue one op in the current cycle; operands are scrambled after the start cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] lit, input int lit_cyc);
        int cyc;
        int busy_cnt;
        bit got;
        StartE   = 1'b1;
        DivOpE   = op;
        SrcAE    = a;
        SrcBE    = b;
        cyc      = 0;
        busy_cnt = 0;
        got      = 1'b0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (BusyE) busy_cnt++;
            if (DoneE) begin
                got = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                SrcAE = $urandom;
                SrcBE = $urandom;
            end
        end
        chk("done_cycle", cyc, lit_cyc);
        chk("busy_cycles", busy_cnt, lit_cyc - 1);
        chk("literal_result", ResultE, lit);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b0;
        StartE = 1'b0;
        DivOpE = 2'b00;
        SrcAE  = 32'd0;
        SrcBE  = 32'd0;
        FlushE = 1'b0;

        chk("ref_divu", ref_div(2'b01, 32'd100, 32'd7), 32'd14);
        chk("ref_rem_neg_divisor", ref_div(2'b10, 32'd7, 32'hFFFF_FFFE), 32'd1);
        chk("ref_div_ovf", ref_div(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
        chk("ref_div_neg", ref_div(2'b00, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_done", {31'd0, DoneE}, 32'd0);
        chk("reset_result", ResultE, 32'd0);
        chk("reset_busy", {31'd0, BusyE}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back ops: StartE stays high across them.
        do_op(2'b01, 32'd100, 32'd7, 32'd14, 34);
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 34);
        do_op(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        do_op(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 34);
        do_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
        do_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
        do_op(2'b00, 32'd0, 32'hFFFF_FFFB, 32'd0, 34);
        StartE = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Flush at CALC cycle 10, then an immediate new op.
        StartE = 1'b1;
        DivOpE = 2'b01;
        SrcAE  = 32'd1000;
        SrcBE  = 32'd3;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        FlushE = 1'b1;
        @(posedge clk);
        #1;
        FlushE = 1'b0;
        StartE = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'd0, BusyE}, 32'd0);
        chk("flush_done", {31'd0, DoneE}, 32'd0);
        @(posedge clk);
        #1;
        do_op(2'b01, 32'd9, 32'd3, 32'd3, 34);
        StartE = 1'b0;

        // Reset at CALC cycle 20.
        StartE = 1'b1;
        DivOpE = 2'b01;
        SrcAE  = 32'd1000;
        SrcBE  = 32'd7;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n  = 1'b0;
        StartE = 1'b0;
        #1;
        chk("rst_mid_done", {31'd0, DoneE}, 32'd0);
        chk("rst_mid_result", ResultE, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;

        do_op(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);
        do_op(2'b00, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 2);
        StartE = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_unit_e.md
# div_unit_e

Iterative RV32M divide/remainder unit in the EX stage of the 5-stage core. It executes DIV, DIVU, REM and REMU with a radix-2 restoring algorithm at one quotient bit per cycle. It raises `BusyE` to the hazard unit, which folds it into `StallF`, `StallD` and an E-stage stall. It honours `FlushE` from the hazard unit to abandon an in-flight operation.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; the iteration count equals `XLEN`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `StartE` in 1: the EX-stage instruction is a divide op. Held high for as long as the instruction sits in E.
- `DivOpE` in 2: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `SrcAE` in XLEN: dividend, post-forwarding.
- `SrcBE` in XLEN: divisor, post-forwarding.
- `FlushE` in 1: kill the E-stage instruction.
- `BusyE` out 1: stall request to the hazard unit.
- `DoneE` out 1: one-cycle pulse; `ResultE` is valid.
- `ResultE` out XLEN: quotient or remainder.

## Operation
- States: IDLE, CALC, DONE. A 5-bit iteration counter `cnt`.
- IDLE with `StartE`=1 and `FlushE`=0:
  - latch op, |A|, |B|, quotient sign (signA^signB) and remainder sign (signA); unsigned ops use raw values and positive signs.
  - Divisor == 0: the next state is DONE with quotient 0xFFFFFFFF and remainder = `SrcAE`, unmodified.
  - DIV/REM with A = 0x80000000 and B = 0xFFFFFFFF: the next state is DONE with quotient 0x80000000 and remainder 0.
  - Otherwise the next state is CALC, with `cnt`=0, remainder register 0, and the quotient register loaded with |A|.
- CALC, each cycle:
  - {rem,quo} shift left 1.
  - Trial-subtract |B| from rem (XLEN+1-bit difference).
  - If non-negative, keep the difference and set quo[0]=1.
  - `cnt`++.
  - When `cnt`==XLEN-1, the next state is DONE. The registered result applies sign correction (two's-complement negate when the sign flag is set) and selects quotient or remainder by `DivOpE[1]`.
- DONE: `DoneE`=1 and `ResultE` is valid. The next state is IDLE unconditionally; `StartE` still high in DONE is the same instruction leaving E and must not restart.
- `BusyE` = (state==IDLE & `StartE`) | (state==CALC). It is 0 in DONE so the pipeline advances at the end of the DONE cycle. It is combinational from state and `StartE` only; no path from `FlushE`.
- `FlushE`=1 in any state: the next state is IDLE. `DoneE` is not asserted next cycle, and `ResultE` holds its last value. `FlushE` has priority over `StartE` and over the CALC→DONE transition. A DONE-cycle flush still leaves `DoneE`=1 for that cycle; the consumer discards it.
- `ResultE` is registered and holds its value outside DONE; it is not cleared on IDLE.

## Timing
- Reset (`rst_n`=0, async):
  - state = IDLE, `cnt` = 0, `DoneE` = 0, `ResultE` = 0, internal registers = 0.
  - `BusyE` = `StartE` during reset; the hazard unit ignores it while the pipeline is in reset.
- Reset mid-CALC aborts immediately. No `DoneE` after release.
- Normal latency: start cycle (IDLE) + 32 CALC + 1 DONE. The instruction occupies E for 34 cycles; `BusyE` is high for 33.
- Special case (zero divisor, overflow): start cycle + DONE. E is occupied for 2 cycles; `BusyE` is high for 1.
- Back-to-back divides: the second `StartE` is seen in the IDLE cycle right after DONE. There are no idle bubbles beyond that.
- Operands are sampled only in the IDLE start cycle. Forwarding changes on `SrcAE`/`SrcBE` during CALC are ignored.

## Test plan
- DIVU 100/7 (`StartE` held) -> `BusyE` high 33 cycles; `DoneE` pulse in cycle 34 with `ResultE`=14. REMU same operands -> 2.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD(-3). REM same operands -> 0xFFFFFFFF(-1). REM 7/-2 -> 1.
- DIVU 5/0 -> `DoneE` in cycle 2, `ResultE`=0xFFFFFFFF. REM 0xFFFFFFF9/0 -> 0xFFFFFFF9.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 2. REM same operands -> 0.
- Start DIVU 1000/3 and assert `FlushE` at CALC cycle 10 -> IDLE next cycle, no `DoneE`, `BusyE` low once `StartE` drops. An immediate new DIVU 9/3 -> 3 after 34 cycles.
- Drop `rst_n` at CALC cycle 20 -> `DoneE`=0 and `ResultE`=0 immediately. After release, no `DoneE` occurs without a new `StartE`.
